// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-clock divider, x/y scan counters, frame counter
// and registered sync/status outputs aligned with the presented x/y position.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int COUNT_W   = 10,
  parameter int FRAME_W   = 8
) (
  input  logic               clk_50MHz,
  input  logic               reset,
  input  logic               enable,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               p_tick,
  output logic [COUNT_W-1:0] x,
  output logic [COUNT_W-1:0] y,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [COUNT_W-1:0] H_LAST   = COUNT_W'(H_TOTAL - 1);
  localparam logic [COUNT_W-1:0] V_LAST   = COUNT_W'(V_TOTAL - 1);
  localparam logic [COUNT_W-1:0] H_VIS    = COUNT_W'(H_DISPLAY);
  localparam logic [COUNT_W-1:0] V_VIS    = COUNT_W'(V_DISPLAY);
  localparam logic [COUNT_W-1:0] HS_FIRST = COUNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [COUNT_W-1:0] HS_LAST  = COUNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [COUNT_W-1:0] VS_FIRST = COUNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [COUNT_W-1:0] VS_LAST  = COUNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic               HS_ON    = 1'(HSYNC_POL);
  localparam logic               VS_ON    = 1'(VSYNC_POL);

  function automatic logic h_active(input logic [COUNT_W-1:0] xv);
    return (xv >= HS_FIRST) && (xv <= HS_LAST);
  endfunction

  function automatic logic v_active(input logic [COUNT_W-1:0] yv);
    return (yv >= VS_FIRST) && (yv <= VS_LAST);
  endfunction

  function automatic logic visible(input logic [COUNT_W-1:0] xv,
                                   input logic [COUNT_W-1:0] yv);
    return (xv < H_VIS) && (yv < V_VIS);
  endfunction

  logic [DIV_W-1:0]   div_cnt;
  logic [DIV_W-1:0]   div_p0;
  logic [COUNT_W-1:0] x_p0;
  logic [COUNT_W-1:0] y_p0;
  logic [FRAME_W-1:0] frame_p0;
  logic               vld_p0;

  // Stage 0: next scan position; status registers are loaded from it so they
  // always describe the x/y presented alongside them.
  always_comb begin
    vld_p0   = enable;
    p_tick   = enable && (div_cnt == DIV_LAST);
    div_p0   = div_cnt;
    x_p0     = x;
    y_p0     = y;
    frame_p0 = frame_count;
    if (enable) begin
      div_p0 = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
    if (p_tick) begin
      if (x == H_LAST) begin
        x_p0 = '0;
        if (y == V_LAST) begin
          y_p0     = '0;
          frame_p0 = frame_count + 1'b1;
        end else begin
          y_p0 = y + 1'b1;
        end
      end else begin
        x_p0 = x + 1'b1;
      end
    end
  end

  // Stage 1: registered state and outputs; a paused cycle holds everything.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      div_cnt     <= '0;
      x           <= '0;
      y           <= '0;
      frame_count <= '0;
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (vld_p0) begin
      div_cnt     <= div_p0;
      x           <= x_p0;
      y           <= y_p0;
      frame_count <= frame_p0;
      hsync       <= h_active(x_p0) ? HS_ON : ~HS_ON;
      vsync       <= v_active(y_p0) ? VS_ON : ~VS_ON;
      video_on    <= visible(x_p0, y_p0);
      line_start  <= (x_p0 == '0);
      frame_start <= (x_p0 == '0) && (y_p0 == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations share clock, reset and enable;
// expected outputs come from the count of enabled clocks since the last reset.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;

  always #5 clk = ~clk;

  // A: 8/2/3/2 x 5/1/2/2, divide by 3, active-low syncs, 3-bit frame counter
  logic hs_a, vs_a, von_a, pt_a, ls_a, fs_a;
  logic [3:0] x_a, y_a;
  logic [2:0] fc_a;
  // B: 4/1/2/1 x 3/1/1/1, divide by 1, active-high syncs, 2-bit frame counter
  logic hs_b, vs_b, von_b, pt_b, ls_b, fs_b;
  logic [2:0] x_b, y_b;
  logic [1:0] fc_b;
  // D: default 640x480 timing
  logic hs_d, vs_d, von_d, pt_d, ls_d, fs_d;
  logic [9:0] x_d, y_d;
  logic [7:0] fc_d;

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .CLK_DIV(3), .HSYNC_POL(0), .VSYNC_POL(0), .COUNT_W(4), .FRAME_W(3)
  ) dut_a (
    .clk_50MHz(clk), .reset(reset), .enable(enable),
    .hsync(hs_a), .vsync(vs_a), .video_on(von_a), .p_tick(pt_a),
    .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
  );

  vga_timing_gen #(
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .CLK_DIV(1), .HSYNC_POL(1), .VSYNC_POL(1), .COUNT_W(3), .FRAME_W(2)
  ) dut_b (
    .clk_50MHz(clk), .reset(reset), .enable(enable),
    .hsync(hs_b), .vsync(vs_b), .video_on(von_b), .p_tick(pt_b),
    .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
  );

  vga_timing_gen dut_d (
    .clk_50MHz(clk), .reset(reset), .enable(enable),
    .hsync(hs_d), .vsync(vs_d), .video_on(von_d), .p_tick(pt_d),
    .x(x_d), .y(y_d), .line_start(ls_d), .frame_start(fs_d), .frame_count(fc_d)
  );

  int checks = 0;
  int passed = 0;

  // Model state: enabled clocks since reset, and whether any enabled edge occurred.
  int n = 0;
  bit loaded = 1'b0;
  bit armed = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      n      <= 0;
      loaded <= 1'b0;
      armed  <= 1'b1;
    end else if (enable) begin
      n      <= n + 1;
      loaded <= 1'b1;
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk(input string tag,
                     input int hd, input int hf, input int hs, input int hb,
                     input int vd, input int vf, input int vs, input int vb,
                     input int dv, input int hp, input int vp, input int fw,
                     input logic [31:0] a_hs, input logic [31:0] a_vs,
                     input logic [31:0] a_von, input logic [31:0] a_pt,
                     input logic [31:0] a_ls, input logic [31:0] a_fs,
                     input logic [31:0] a_x, input logic [31:0] a_y,
                     input logic [31:0] a_fc);
    int ht, vt, pix, ex, ey, efc, ehs, evs, evon, els, efs, ept;
    ht   = hd + hf + hs + hb;
    vt   = vd + vf + vs + vb;
    pix  = n / dv;
    ex   = pix % ht;
    ey   = (pix / ht) % vt;
    efc  = (pix / (ht * vt)) % (1 << fw);
    ehs  = (loaded && ex >= hd + hf && ex < hd + hf + hs) ? hp : 1 - hp;
    evs  = (loaded && ey >= vd + vf && ey < vd + vf + vs) ? vp : 1 - vp;
    evon = (loaded && ex < hd && ey < vd) ? 1 : 0;
    els  = (loaded && ex == 0) ? 1 : 0;
    efs  = (loaded && ex == 0 && ey == 0) ? 1 : 0;
    ept  = (enable && (n % dv) == dv - 1) ? 1 : 0;
    cmp({tag, ".x"}, a_x, 32'(ex));
    cmp({tag, ".y"}, a_y, 32'(ey));
    cmp({tag, ".frame_count"}, a_fc, 32'(efc));
    cmp({tag, ".hsync"}, a_hs, 32'(ehs));
    cmp({tag, ".vsync"}, a_vs, 32'(evs));
    cmp({tag, ".video_on"}, a_von, 32'(evon));
    cmp({tag, ".line_start"}, a_ls, 32'(els));
    cmp({tag, ".frame_start"}, a_fs, 32'(efs));
    cmp({tag, ".p_tick"}, a_pt, 32'(ept));
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("A", 8, 2, 3, 2, 5, 1, 2, 2, 3, 0, 0, 3,
          32'(hs_a), 32'(vs_a), 32'(von_a), 32'(pt_a), 32'(ls_a), 32'(fs_a),
          32'(x_a), 32'(y_a), 32'(fc_a));
      chk("B", 4, 1, 2, 1, 3, 1, 1, 1, 1, 1, 1, 2,
          32'(hs_b), 32'(vs_b), 32'(von_b), 32'(pt_b), 32'(ls_b), 32'(fs_b),
          32'(x_b), 32'(y_b), 32'(fc_b));
      chk("D", 640, 16, 96, 48, 480, 10, 2, 33, 2, 0, 0, 8,
          32'(hs_d), 32'(vs_d), 32'(von_d), 32'(pt_d), 32'(ls_d), 32'(fs_d),
          32'(x_d), 32'(y_d), 32'(fc_d));
    end
  end

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #2;
    end
  endtask

  int hs_low, von_low, ls_high;
  int fc_seq [4] = '{1, 2, 3, 0};

  initial begin
    cyc(5);
    cmp("rst.hsync_d", 32'(hs_d), 1);
    cmp("rst.vsync_d", 32'(vs_d), 1);
    cmp("rst.video_on_d", 32'(von_d), 0);
    cmp("rst.hsync_b", 32'(hs_b), 0);

    reset = 1'b0;
    cyc(1);
    cmp("rel.video_on_d", 32'(von_d), 1);
    cmp("rel.line_start_d", 32'(ls_d), 1);
    cmp("rel.frame_start_d", 32'(fs_d), 1);
    cmp("rel.hsync_d", 32'(hs_d), 1);
    cmp("rel.p_tick_d", 32'(pt_d), 1);
    cyc(1);
    cmp("rel2.x_d", 32'(x_d), 1);
    cmp("rel2.p_tick_d", 32'(pt_d), 0);
    cyc(11);
    cmp("n13.x_b", 32'(x_b), 5);
    cmp("n13.y_b", 32'(y_b), 1);
    cmp("n13.hsync_b", 32'(hs_b), 1);
    cyc(24);
    cmp("n37.y_b", 32'(y_b), 4);
    cmp("n37.hsync_b", 32'(hs_b), 1);
    cmp("n37.vsync_b", 32'(vs_b), 1);

    // single-clock reset while both syncs of B are asserted
    reset = 1'b1;
    cyc(1);
    cmp("midrst.x_b", 32'(x_b), 0);
    cmp("midrst.y_b", 32'(y_b), 0);
    cmp("midrst.hsync_b", 32'(hs_b), 0);
    cmp("midrst.vsync_b", 32'(vs_b), 0);
    cmp("midrst.video_on_b", 32'(von_b), 0);
    cmp("midrst.frame_count_b", 32'(fc_b), 0);
    reset = 1'b0;

    // one full default line
    hs_low = 0; von_low = 0; ls_high = 0;
    repeat (1600) begin
      cyc(1);
      if (hs_d == 1'b0) hs_low++;
      if (von_d == 1'b0) von_low++;
      if (ls_d == 1'b1) ls_high++;
    end
    cmp("line.hsync_low_clks", 32'(hs_low), 192);
    cmp("line.video_off_clks", 32'(von_low), 320);
    cmp("line.line_start_clks", 32'(ls_high), 2);
    cmp("line.x_d", 32'(x_d), 0);
    cmp("line.y_d", 32'(y_d), 1);

    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(303);
    cmp("n303.x_a", 32'(x_a), 11);
    cmp("n303.y_a", 32'(y_a), 6);
    cmp("n303.hsync_a", 32'(hs_a), 0);
    cmp("n303.vsync_a", 32'(vs_a), 0);
    cmp("n303.x_d", 32'(x_d), 151);

    // pause at x=300 on the default timing
    cyc(297);
    cmp("pause.x_d", 32'(x_d), 300);
    enable = 1'b0;
    cyc(37);
    cmp("paused.x_d", 32'(x_d), 300);
    cmp("paused.p_tick_d", 32'(pt_d), 0);
    cmp("paused.video_on_d", 32'(von_d), 1);
    enable = 1'b1;
    cyc(1);
    cmp("resume1.x_d", 32'(x_d), 300);
    cyc(1);
    cmp("resume2.x_d", 32'(x_d), 301);

    // frame counter wrap on B: 48 clocks per frame
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    for (int f = 0; f < 4; f++) begin
      cyc(48);
      cmp("wrap.frame_count_b", 32'(fc_b), 32'(fc_seq[f]));
      cmp("wrap.frame_start_b", 32'(fs_b), 1);
    end
    cmp("wrap.frame_count_a", 32'(fc_a), 0);

    // randomized enable with occasional resets
    for (int i = 0; i < 5000; i++) begin
      reset  = ($urandom_range(0, 399) == 0);
      enable = ($urandom_range(0, 3) != 0);
      cyc(1);
    end
    reset = 1'b0;
    enable = 1'b1;
    cyc(2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
